// File: rtl/tw_pkg.sv
// tw_pkg: shared constants and types for the twiddle table writer.
// Binary angle format is 16 bits with pi/2 == 2^14.
package tw_pkg;

  localparam int ANG_W = 16;

  localparam real CORDIC_K = 0.6072529;

  localparam logic [15:0] ATAN_TAB [0:15] = '{
    16'd8192, 16'd4836, 16'd2555, 16'd1297,
    16'd651,  16'd326,  16'd163,  16'd81,
    16'd41,   16'd20,   16'd10,   16'd5,
    16'd3,    16'd1,    16'd1,    16'd0
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROT,
    ST_WRITE,
    ST_DONE
  } tw_state_e;

  // Initial CORDIC x: gain-compensated 1.0 with 4 guard bits
  function automatic int cordic_x0(input int w);
    return $rtoi(CORDIC_K * (2.0 ** (w + 2)) + 0.5);
  endfunction

endpackage

// File: rtl/cordic_rot_iter.sv
// cordic_rot_iter: x/y/z CORDIC state, one micro-rotation per cycle.
// Next-state values are exported so the last rotation can be captured.
module cordic_rot_iter
  import tw_pkg::*;
#(
  parameter int DW = 18,
  parameter int ZW = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 rot_i,
  input  logic [3:0]           iter_i,
  input  logic signed [DW-1:0] x0_i,
  input  logic signed [ZW-1:0] z0_i,
  output logic signed [DW-1:0] x_nxt_o,
  output logic signed [DW-1:0] y_nxt_o
);

  logic signed [DW-1:0] x_q, x_d;
  logic signed [DW-1:0] y_q, y_d;
  logic signed [ZW-1:0] z_q, z_d;
  logic signed [ZW-1:0] at;

  // Micro-rotation; direction follows the sign of residual angle
  always_comb begin
    at = ZW'(ATAN_TAB[iter_i]);
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    if (z_q[ZW-1]) begin
      x_d = x_q + (y_q >>> iter_i);
      y_d = y_q - (x_q >>> iter_i);
      z_d = z_q + at;
    end else begin
      x_d = x_q - (y_q >>> iter_i);
      y_d = y_q + (x_q >>> iter_i);
      z_d = z_q - at;
    end
  end

  // Datapath registers: load a new entry or apply one rotation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else if (load_i) begin
      x_q <= x0_i;
      y_q <= '0;
      z_q <= z0_i;
    end else if (rot_i) begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  end

  assign x_nxt_o = x_d;
  assign y_nxt_o = y_d;

endmodule

// File: rtl/tw_table_writer.sv
// tw_table_writer: CORDIC twiddle generator writing one FFT stage table.
// Entry k holds cos/-sin of pi*k/N, N = 2^(stage_FFT-1).
module tw_table_writer
  import tw_pkg::*;
#(
  parameter int stage_FFT      = 6,
  parameter int word_length_tw = 14,
  parameter int ITER           = 14
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             wr_en,
  output logic [stage_FFT-2:0]             wr_addr,
  output logic signed [word_length_tw-1:0] wr_cos,
  output logic signed [word_length_tw-1:0] wr_sin
);

  localparam int AW = stage_FFT - 1;
  localparam int W  = word_length_tw;
  localparam int DW = W + 4;
  localparam int ZW = ANG_W + 2;

  localparam logic signed [DW-1:0] ONE  = DW'(1 << (W - 2));
  localparam logic signed [DW-1:0] HALF = DW'(8);
  localparam logic signed [DW-1:0] X0   = DW'(cordic_x0(W));
  localparam logic [3:0]           ITER_LAST = 4'(ITER - 1);
  localparam logic [AW-1:0]        K_LAST = '1;

  tw_state_e state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [3:0]    iter_q, iter_d;
  logic          load, rot;

  logic          busy_q, done_q, wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic signed [W-1:0] wr_cos_q, wr_sin_q;
  logic signed [W-1:0] cos_d, sin_d;

  logic [ANG_W-2:0]     ang;
  logic                 fold, byp;
  logic signed [ZW-1:0] z0;
  logic signed [DW-1:0] x_nxt, y_nxt;
  logic signed [DW-1:0] xr, yr, c_v, s_v;

  assign ang  = (ANG_W-1)'(k_q) << (15 - AW);
  assign fold = ang[ANG_W-2];
  assign byp  = (ang[ANG_W-3:0] == '0);
  assign z0   = ZW'(ang[ANG_W-3:0]);

  cordic_rot_iter #(
    .DW(DW),
    .ZW(ZW)
  ) u_rot (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .rot_i  (rot),
    .iter_i (iter_q),
    .x0_i   (X0),
    .z0_i   (z0),
    .x_nxt_o(x_nxt),
    .y_nxt_o(y_nxt)
  );

  function automatic logic signed [DW-1:0] sat(
    input logic signed [DW-1:0] v
  );
    if (v > ONE) return ONE;
    if (v < -ONE) return -ONE;
    return v;
  endfunction

  // Round, axis bypass, quadrant unfold, negate sin, saturate
  always_comb begin
    xr = (x_nxt + HALF) >>> 4;
    yr = (y_nxt + HALF) >>> 4;
    if (byp) begin
      xr = ONE;
      yr = '0;
    end
    if (fold) begin
      c_v = -yr;
      s_v = xr;
    end else begin
      c_v = xr;
      s_v = yr;
    end
    s_v = -s_v;
    cos_d = W'(sat(c_v));
    sin_d = W'(sat(s_v));
  end

  // Sequencer: next state, entry and iteration counters
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    iter_d = iter_q;
    load = 1'b0;
    rot = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        k_d = '0;
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load = 1'b1;
        iter_d = '0;
        state_d = ST_ROT;
      end
      ST_ROT: begin
        rot = 1'b1;
        iter_d = iter_q + 4'd1;
        if (iter_q == ITER_LAST) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (k_q == K_LAST) begin
          state_d = ST_DONE;
        end else begin
          k_d = k_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        k_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q <= '0;
      iter_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      iter_q <= iter_d;
    end
  end

  // Registered status and write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_cos_q <= '0;
      wr_sin_q <= '0;
    end else begin
      busy_q <= (state_d != ST_IDLE);
      done_q <= (state_d == ST_DONE);
      wr_en_q <= (state_d == ST_WRITE);
      if (state_d == ST_WRITE) begin
        wr_addr_q <= k_q;
        wr_cos_q <= cos_d;
        wr_sin_q <= sin_d;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_cos  = wr_cos_q;
  assign wr_sin  = wr_sin_q;

endmodule

// File: tb/tb_tw_table_writer.sv
// tb_tw_table_writer: directed bench for the twiddle table writer.
// Two instances: stage_FFT=6 (32 entries) and stage_FFT=10 (512 entries).
module tb_tw_table_writer;

  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0;
  logic start_a = 1'b0;
  logic busy_a, done_a, wr_en_a;
  logic [4:0] addr_a;
  logic signed [13:0] cos_a, sin_a;

  logic rst_b = 1'b0;
  logic start_b = 1'b0;
  logic busy_b, done_b, wr_en_b;
  logic [8:0] addr_b;
  logic signed [13:0] cos_b, sin_b;

  int checks = 0;
  int failures = 0;

  int wn[$];
  int wa[$];
  int dn[$];
  int ca[32];
  int sa[32];
  int busy_first;
  int busy_514;
  int busy_late;

  tw_table_writer u_a (
    .clk    (clk),
    .rst_n  (rst_a),
    .start  (start_a),
    .busy   (busy_a),
    .done   (done_a),
    .wr_en  (wr_en_a),
    .wr_addr(addr_a),
    .wr_cos (cos_a),
    .wr_sin (sin_a)
  );

  tw_table_writer #(
    .stage_FFT(10)
  ) u_b (
    .clk    (clk),
    .rst_n  (rst_b),
    .start  (start_b),
    .busy   (busy_b),
    .done   (done_b),
    .wr_en  (wr_en_b),
    .wr_addr(addr_b),
    .wr_cos (cos_b),
    .wr_sin (sin_b)
  );

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  // Run DUT A for ncyc cycles after a start, logging writes and done
  task automatic run_a(input int extra_at, input bit start_in_done,
                       input int ncyc);
    wn.delete();
    wa.delete();
    dn.delete();
    for (int i = 0; i < 32; i++) begin
      ca[i] = 99999;
      sa[i] = 99999;
    end
    busy_late = 0;
    busy_514 = -1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    busy_first = int'(busy_a);
    for (int n = 1; n <= ncyc; n++) begin
      if (wr_en_a) begin
        wn.push_back(n);
        wa.push_back(int'(addr_a));
        ca[addr_a] = int'(cos_a);
        sa[addr_a] = int'(sin_a);
      end
      if (done_a) dn.push_back(n);
      if (n == 514) busy_514 = int'(busy_a);
      if (n >= 514 && busy_a) busy_late++;
      start_a = (n == extra_at) || (start_in_done && done_a);
      @(posedge clk); #1;
    end
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy_a, done_a, wr_en_a, addr_a, cos_a, sin_a} !== '0) begin
      failures++;
      $display("FAIL reset_a got=%b,%b,%b,%0d,%0d,%0d exp=all 0",
               busy_a, done_a, wr_en_a, addr_a, cos_a, sin_a);
    end
    checks++;
    if ({busy_b, done_b, wr_en_b, addr_b, cos_b, sin_b} !== '0) begin
      failures++;
      $display("FAIL reset_b got=%b,%b,%b,%0d exp=all 0",
               busy_b, done_b, wr_en_b, addr_b);
    end
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({busy_a, wr_en_a, done_a} !== 3'b000) begin
      failures++;
      $display("FAIL idle_no_start got=%b%b%b exp=000",
               busy_a, wr_en_a, done_a);
    end
  endtask

  task automatic test_full_run();
    int bad;
    run_a(0, 1'b0, 530);
    checks++;
    if (wn.size() != 32) begin
      failures++;
      $display("FAIL write_count got=%0d exp=32", wn.size());
    end
    bad = 0;
    foreach (wn[i]) begin
      if (wn[i] != (i + 1) * 16 || wa[i] != i) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL write_timing_addr got=%0d bad writes exp=0", bad);
    end
    checks++;
    if (dn.size() != 1 || dn[0] != 513) begin
      failures++;
      $display("FAIL done_time got=%0d pulses first=%0d exp=1 at 513",
               dn.size(), (dn.size() > 0) ? dn[0] : -1);
    end
    checks++;
    if (busy_first != 1 || busy_514 != 0) begin
      failures++;
      $display("FAIL busy_window got=%0d/%0d exp=1/0",
               busy_first, busy_514);
    end
    checks++;
    if (ca[0] != 4096 || sa[0] != 0) begin
      failures++;
      $display("FAIL entry0 got=%0d,%0d exp=4096,0", ca[0], sa[0]);
    end
    checks++;
    if (ca[16] != 0 || sa[16] != -4096) begin
      failures++;
      $display("FAIL entry16 got=%0d,%0d exp=0,-4096", ca[16], sa[16]);
    end
    checks++;
    if (ca[8] < 2895 || ca[8] > 2897 || sa[8] < -2897 || sa[8] > -2895) begin
      failures++;
      $display("FAIL entry8 got=%0d,%0d exp=2896,-2896 +-1", ca[8], sa[8]);
    end
    checks++;
    if (ca[31] < -4077 || ca[31] > -4075 ||
        sa[31] < -402 || sa[31] > -400) begin
      failures++;
      $display("FAIL entry31 got=%0d,%0d exp=-4076,-401 +-1",
               ca[31], sa[31]);
    end
    for (int k = 0; k < 32; k++) begin
      int ec, es, dc, ds;
      ec = rnd(4096.0 * $cos(PI * k / 32.0));
      es = rnd(-4096.0 * $sin(PI * k / 32.0));
      dc = ca[k] - ec;
      ds = sa[k] - es;
      checks++;
      if (dc > 1 || dc < -1 || ds > 1 || ds < -1) begin
        failures++;
        $display("FAIL sweep_k%0d got=%0d,%0d exp=%0d,%0d +-1",
                 k, ca[k], sa[k], ec, es);
      end
    end
  endtask

  task automatic test_start_ignored();
    run_a(100, 1'b1, 560);
    checks++;
    if (wn.size() != 32) begin
      failures++;
      $display("FAIL ign_write_count got=%0d exp=32", wn.size());
    end
    checks++;
    if (dn.size() != 1) begin
      failures++;
      $display("FAIL ign_done_count got=%0d exp=1", dn.size());
    end
    checks++;
    if (busy_late != 0) begin
      failures++;
      $display("FAIL ign_restart got=%0d busy cycles exp=0", busy_late);
    end
  endtask

  task automatic test_reset_midrun();
    int wrs;
    int bsy;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int n = 1; n < 200; n++) begin
      @(posedge clk); #1;
    end
    rst_a = 1'b0;
    #1;
    checks++;
    if ({busy_a, done_a, wr_en_a, addr_a, cos_a, sin_a} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%b,%b,%b,%0d,%0d,%0d exp=all 0",
               busy_a, done_a, wr_en_a, addr_a, cos_a, sin_a);
    end
    wrs = 0;
    bsy = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (wr_en_a) wrs++;
    end
    rst_a = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (wr_en_a) wrs++;
      if (busy_a) bsy++;
    end
    checks++;
    if (wrs != 0 || bsy != 0) begin
      failures++;
      $display("FAIL post_reset_quiet got=%0d wr,%0d busy exp=0,0",
               wrs, bsy);
    end
    run_a(0, 1'b0, 520);
    checks++;
    if (wn.size() != 32 || wa[0] != 0 || wn[0] != 16) begin
      failures++;
      $display("FAIL regen_start got=%0d writes first@%0d exp=32 first@16",
               wn.size(), (wn.size() > 0) ? wn[0] : -1);
    end
    checks++;
    if (ca[0] != 4096 || sa[0] != 0 || ca[16] != 0 || sa[16] != -4096) begin
      failures++;
      $display("FAIL regen_values got=%0d,%0d,%0d,%0d exp=4096,0,0,-4096",
               ca[0], sa[0], ca[16], sa[16]);
    end
  endtask

  task automatic test_stage10();
    int cnt, bad, dcnt, dnb;
    int c256, s256, c128, s128;
    cnt = 0;
    bad = 0;
    dcnt = 0;
    dnb = -1;
    c256 = 99999;
    s256 = 99999;
    c128 = 99999;
    s128 = 99999;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int n = 1; n <= 8210; n++) begin
      if (wr_en_b) begin
        if (n != (cnt + 1) * 16 || int'(addr_b) != cnt) bad++;
        if (addr_b == 9'd256) begin
          c256 = int'(cos_b);
          s256 = int'(sin_b);
        end
        if (addr_b == 9'd128) begin
          c128 = int'(cos_b);
          s128 = int'(sin_b);
        end
        cnt++;
      end
      if (done_b) begin
        dcnt++;
        dnb = n;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (cnt != 512 || bad != 0) begin
      failures++;
      $display("FAIL s10_writes got=%0d writes %0d bad exp=512,0", cnt, bad);
    end
    checks++;
    if (c256 != 0 || s256 != -4096) begin
      failures++;
      $display("FAIL s10_entry256 got=%0d,%0d exp=0,-4096", c256, s256);
    end
    checks++;
    if (c128 < 2895 || c128 > 2897 || s128 < -2897 || s128 > -2895) begin
      failures++;
      $display("FAIL s10_entry128 got=%0d,%0d exp=2896,-2896 +-1",
               c128, s128);
    end
    checks++;
    if (dcnt != 1 || dnb != 8193) begin
      failures++;
      $display("FAIL s10_done got=%0d pulses at %0d exp=1 at 8193",
               dcnt, dnb);
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_start_ignored();
    test_reset_midrun();
    test_stage10();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tw_table_writer.md
# tw_table_writer

Twiddle-factor table generator for the parallel FFT. After `start`, it computes the cos/sin twiddle pairs for one FFT stage with an iterative CORDIC. It then writes them, one entry at a time, into the RAM-based twiddle store that the stage's twiddle reader (`en_rd`/`rd_ptr_angle`) later reads. It replaces hand-written initial tables, so any `stage_FFT` value can be supported without regenerating constants.

## Interface
- `stage_FFT`, 6: the table holds N = 2^(stage_FFT-1) entries; legal range 2..16.
- `word_length_tw`, 14: signed twiddle width; Q1.(word_length_tw-2), so 1.0 = 2^(word_length_tw-2) (4096 at 14).
- `ITER`, 14: CORDIC micro-rotations per entry; legal range 8..16.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request to regenerate the whole table.
- `busy` output 1: high while generation is in progress.
- `done` output 1: one-cycle pulse after the last write.
- `wr_en` output 1: write strobe to the twiddle store.
- `wr_addr` output stage_FFT-1: table index k.
- `wr_cos` output word_length_tw (signed): round(2^(W-2)·cos(πk/N)).
- `wr_sin` output word_length_tw (signed): round(−2^(W-2)·sin(πk/N)).

## Operation
- Entry k angle: θk = πk/N, for k = 0..N−1, so θk lies in [0, π).
- Angle representation: 16-bit binary angle, where π/2 = 2^14. Entry k angle is k << (16 − stage_FFT).
- Quadrant fold: if θ ≥ π/2, rotate by θ − π/2, then map the result as cos = −sin', sin = cos'.
- CORDIC datapath width is W+4 guard bits. Initial x = round(K·2^(W+2)), where K = 0.6072529; y = 0 and z = folded angle.
- Each iteration i: d = sign(z); x −= d·(y>>>i); y += d·(x>>>i); z −= d·atan_tab[i].
- Output stage: round-half-up drop of 4 guard bits, then the quadrant mapping, then negate sin, then saturate to ±2^(W-2).
- Axis bypass: for folded angle == 0 the output is forced to the exact values (1.0, 0) before mapping. Entry 0 and entry N/2 are therefore exact.
- Accuracy: every entry is within ±1 LSB of the ideal rounded value.
- FSM states:
  - IDLE: `start` → LOAD.
  - LOAD (1 cycle): init x/y/z for entry k → ROT.
  - ROT (ITER cycles, iteration counter 0..ITER−1) → WRITE.
  - WRITE (1 cycle, `wr_en` = 1): if k = N−1 → DONE; else k++ → LOAD.
  - DONE (1 cycle, `done` = 1) → IDLE.
- `busy` is high in LOAD, ROT, WRITE and DONE.
- `start` while busy is ignored. There is no queuing.
- `start` in the DONE cycle is ignored. `start` on the first IDLE cycle is accepted.
- `wr_addr`, `wr_cos` and `wr_sin` are valid only when `wr_en` = 1. They hold their last values otherwise.

## Timing
- Reset values: `busy` = 0, `done` = 0, `wr_en` = 0, `wr_addr` = 0, `wr_cos` = 0, `wr_sin` = 0. FSM in IDLE, k = 0.
- Reset asserted mid-run aborts at once. No further `wr_en` occurs; the table is left partially written and is regenerated on the next `start`.
- All outputs are registered, with no combinational path from inputs to outputs.
- `start` sampled at edge t0 gives `busy` = 1 from t0+1.
- Entry k write cycle is t0 + (k+1)(ITER+2).
- Per-entry period is ITER+2 cycles. `wr_en` is never high on consecutive cycles.
- `done` = 1 in cycle t0 + N(ITER+2) + 1. `busy` falls the cycle after.
- For stage_FFT = 6 and ITER = 14: 32 entries × 16 cycles = 512 cycles, and `done` occurs at t0+513.

## Structure
- Shared package `tw_pkg` holds:
  - `atan_tab[0:15]`: round(atan(2^-i)/(π/2)·2^14), 16-bit.
  - the CORDIC gain constant.
  - the angle-width constant (16).
  - the FSM state enum.
- Natural sub-module: `cordic_rot_iter`. It contains the x/y/z registers, the iteration counter input, and one micro-rotation per cycle.
- The top level contains the FSM, the entry counter, the fold/bypass/round/saturate output stage, and the write port.

## Test plan
- S=6, W=14, ITER=14, reset then `start` → exactly 32 `wr_en` pulses, addresses 0..31 in order, `done` at t0+513, `busy` low at t0+514.
- Entry 0 → cos = 4096 (0x1000), sin = 0 exact. Entry 16 → cos = 0, sin = −4096 exact.
- Entry 8 → cos 2896, sin −2896 (±1). Entry 31 → cos −4076, sin −401 (±1). Sweep all 32 entries against the real-valued model, max error ≤ 1 LSB.
- `start` pulsed at t0+100 and in the DONE cycle → ignored: still 32 writes, a single `done`, no restart.
- `rst_n` low at t0+200 → all outputs 0 asynchronously, no `wr_en` afterwards. A fresh `start` regenerates from address 0 with correct values.
- S=10 → 512 entries, period 16 cycles, entry 256 → (0, −4096) exact, `done` at t0+8193.
